// File: rtl/bound_flasher_pkg.sv
// Shared types and defaults for the parametrised bound flasher.
// The state enum doubles as the externally visible mode encoding.
package bound_flasher_pkg;

  localparam int MODE_W       = 3;
  localparam int DEF_N_LED    = 16;
  localparam int DEF_B_LO     = 5;
  localparam int DEF_B_HI     = 10;
  localparam int DEF_TICK_DIV = 1;

  typedef enum logic [MODE_W-1:0] {
    IDLE    = 3'd0,
    UP_FULL = 3'd1,
    DN_LO   = 3'd2,
    UP_MID  = 3'd3,
    DN_ZERO = 3'd4,
    UP_LO   = 3'd5,
    DN_END  = 3'd6
  } state_t;

  function automatic logic is_up(input state_t s);
    return (s == UP_FULL) || (s == UP_MID) || (s == UP_LO);
  endfunction

  // Successor taken once a phase has reached its target; flick only
  // matters at the three bottom-of-descent points (kickback).
  function automatic state_t next_state(input state_t s, input logic flick);
    case (s)
      UP_FULL: return DN_LO;
      DN_LO:   return flick ? UP_FULL : UP_MID;
      UP_MID:  return DN_ZERO;
      DN_ZERO: return flick ? UP_MID : UP_LO;
      UP_LO:   return DN_END;
      DN_END:  return flick ? UP_LO : IDLE;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/bound_flasher_gen_tick.sv
// Free-running prescaler producing a one-cycle step strobe every TICK_DIV clocks.
module flasher_tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] pre;
  logic          last;

  assign last = (pre == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) pre <= '0;
    else     pre <= last ? '0 : pre + 1'b1;
  end

  // Gated so the strobe reads low while reset is held, even with TICK_DIV=1.
  assign tick = last & ~rst;

endmodule

// File: rtl/bound_flasher_gen.sv
// N-lamp bound flasher: fixed up/down sweep with two bound points and
// flick-controlled kickback, stepped by an internal prescaler tick.
module bound_flasher_gen
  import bound_flasher_pkg::*;
#(
  parameter int N_LED    = DEF_N_LED,
  parameter int B_LO     = DEF_B_LO,
  parameter int B_HI     = DEF_B_HI,
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flick,
  output logic [N_LED-1:0]  led_out,
  output logic [MODE_W-1:0] mode,
  output logic              busy,
  output logic              tick
);

  localparam int CW = $clog2(N_LED + 1);

  if (N_LED < 4) begin : g_bad_n
    $error("bound_flasher_gen: N_LED must be >= 4");
  end
  if (!(B_LO > 0 && B_LO < B_HI && B_HI < N_LED)) begin : g_bad_b
    $error("bound_flasher_gen: need 0 < B_LO < B_HI < N_LED");
  end
  if (TICK_DIV < 1) begin : g_bad_div
    $error("bound_flasher_gen: TICK_DIV must be >= 1");
  end

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] target;

  flasher_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    target = '0;
    case (state)
      UP_FULL: target = CW'(N_LED);
      DN_LO:   target = CW'(B_LO);
      UP_MID:  target = CW'(B_HI);
      UP_LO:   target = CW'(B_LO);
      default: target = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            cnt <= '0;
            if (flick) state <= UP_FULL;
          end
        end
        UP_FULL, DN_LO, UP_MID, DN_ZERO, UP_LO, DN_END: begin
          if (tick) begin
            if (cnt != target) cnt <= is_up(state) ? cnt + 1'b1 : cnt - 1'b1;
            else               state <= next_state(state, flick);
          end
        end
        // Unused encoding recovers on the next clock without waiting for a tick.
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    led_out = '0;
    for (int unsigned i = 0; i < N_LED; i++) led_out[i] = (cnt > CW'(i));
  end

  assign mode = state;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bound_flasher_gen.sv
// Directed bench for bound_flasher_gen: default 16-lamp build with
// TICK_DIV=1 plus a small 8-lamp build with TICK_DIV=4.
module tb_bound_flasher_gen;

  logic        clk = 1'b0;
  logic        rst_a, flick_a, busy_a, tick_a;
  logic [15:0] led_a;
  logic [2:0]  mode_a;
  logic        rst_s, flick_s, busy_s, tick_s;
  logic [7:0]  led_s;
  logic [2:0]  mode_s;

  int checks = 0;
  int errors = 0;
  int tk = 0;

  always #5 clk = ~clk;

  bound_flasher_gen dut_a (
    .clk(clk), .rst(rst_a), .flick(flick_a),
    .led_out(led_a), .mode(mode_a), .busy(busy_a), .tick(tick_a)
  );

  bound_flasher_gen #(.N_LED(8), .B_LO(2), .B_HI(5), .TICK_DIV(4)) dut_s (
    .clk(clk), .rst(rst_s), .flick(flick_s),
    .led_out(led_s), .mode(mode_s), .busy(busy_s), .tick(tick_s)
  );

  task automatic apply_reset();
    rst_a = 1'b1; flick_a = 1'b0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    tk = 0;
  endtask

  task automatic start_sweep();
    flick_a = 1'b1;
    @(negedge clk);
    flick_a = 1'b0;
    tk = 1;
  endtask

  task automatic to_tick(input int k);
    repeat (k - tk) @(negedge clk);
    tk = k;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; flick_a = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (led_a !== 16'h0000 || mode_a !== 3'd0 || busy_a !== 1'b0 || tick_a !== 1'b0) begin
      errors++;
      $display("FAIL reset: led=%h mode=%0d busy=%b tick=%b, want 0000/0/0/0", led_a, mode_a, busy_a, tick_a);
    end
    rst_a = 1'b0;
    tk = 0;
  endtask

  task automatic test_idle_hold();
    repeat (100) @(negedge clk);
    checks++;
    if (led_a !== 16'h0000 || mode_a !== 3'd0 || busy_a !== 1'b0 || tick_a !== 1'b1) begin
      errors++;
      $display("FAIL idle_hold: led=%h mode=%0d busy=%b tick=%b, want 0000/0/0/1", led_a, mode_a, busy_a, tick_a);
    end
  endtask

  task automatic test_full_sweep();
    apply_reset();
    start_sweep();
    checks++;
    if (mode_a !== 3'd1 || led_a !== 16'h0000 || busy_a !== 1'b1) begin
      errors++; $display("FAIL sweep_t1: mode=%0d led=%h busy=%b, want 1/0000/1", mode_a, led_a, busy_a);
    end
    to_tick(17);
    checks++;
    if (led_a !== 16'hFFFF || mode_a !== 3'd1) begin
      errors++; $display("FAIL sweep_t17: led=%h mode=%0d, want FFFF/1", led_a, mode_a);
    end
    to_tick(18);
    checks++;
    if (led_a !== 16'hFFFF || mode_a !== 3'd2) begin
      errors++; $display("FAIL sweep_t18: led=%h mode=%0d, want FFFF/2", led_a, mode_a);
    end
    to_tick(29);
    checks++;
    if (led_a !== 16'h001F || mode_a !== 3'd2) begin
      errors++; $display("FAIL sweep_t29: led=%h mode=%0d, want 001F/2", led_a, mode_a);
    end
    to_tick(35);
    checks++;
    if (led_a !== 16'h03FF || mode_a !== 3'd3) begin
      errors++; $display("FAIL sweep_t35: led=%h mode=%0d, want 03FF/3", led_a, mode_a);
    end
    to_tick(46);
    checks++;
    if (led_a !== 16'h0000 || mode_a !== 3'd4) begin
      errors++; $display("FAIL sweep_t46: led=%h mode=%0d, want 0000/4", led_a, mode_a);
    end
    to_tick(52);
    checks++;
    if (led_a !== 16'h001F || mode_a !== 3'd5) begin
      errors++; $display("FAIL sweep_t52: led=%h mode=%0d, want 001F/5", led_a, mode_a);
    end
    to_tick(58);
    checks++;
    if (led_a !== 16'h0000 || mode_a !== 3'd6 || busy_a !== 1'b1) begin
      errors++; $display("FAIL sweep_t58: led=%h mode=%0d busy=%b, want 0000/6/1", led_a, mode_a, busy_a);
    end
    to_tick(59);
    checks++;
    if (led_a !== 16'h0000 || mode_a !== 3'd0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL sweep_t59: led=%h mode=%0d busy=%b, want 0000/0/0", led_a, mode_a, busy_a);
    end
    to_tick(70);
    checks++;
    if (mode_a !== 3'd0 || led_a !== 16'h0000) begin
      errors++; $display("FAIL sweep_stays_idle: mode=%0d led=%h, want 0/0000", mode_a, led_a);
    end
  endtask

  task automatic test_kick_lo();
    apply_reset();
    start_sweep();
    to_tick(29);
    flick_a = 1'b1;
    to_tick(30);
    flick_a = 1'b0;
    checks++;
    if (mode_a !== 3'd1 || led_a !== 16'h001F) begin
      errors++; $display("FAIL kick_lo_t30: mode=%0d led=%h, want 1/001F", mode_a, led_a);
    end
    to_tick(31);
    checks++;
    if (led_a !== 16'h003F || mode_a !== 3'd1) begin
      errors++; $display("FAIL kick_lo_t31: led=%h mode=%0d, want 003F/1", led_a, mode_a);
    end
    to_tick(41);
    checks++;
    if (led_a !== 16'hFFFF || mode_a !== 3'd1) begin
      errors++; $display("FAIL kick_lo_t41: led=%h mode=%0d, want FFFF/1", led_a, mode_a);
    end
    to_tick(42);
    checks++;
    if (mode_a !== 3'd2) begin
      errors++; $display("FAIL kick_lo_t42: mode=%0d, want 2", mode_a);
    end
  endtask

  task automatic test_kick_zero();
    apply_reset();
    start_sweep();
    to_tick(46);
    flick_a = 1'b1;
    to_tick(47);
    flick_a = 1'b0;
    checks++;
    if (mode_a !== 3'd3 || led_a !== 16'h0000) begin
      errors++; $display("FAIL kick_zero_t47: mode=%0d led=%h, want 3/0000", mode_a, led_a);
    end
    to_tick(48);
    checks++;
    if (led_a !== 16'h0001 || mode_a !== 3'd3) begin
      errors++; $display("FAIL kick_zero_t48: led=%h mode=%0d, want 0001/3", led_a, mode_a);
    end
    to_tick(57);
    checks++;
    if (led_a !== 16'h03FF || mode_a !== 3'd3) begin
      errors++; $display("FAIL kick_zero_t57: led=%h mode=%0d, want 03FF/3", led_a, mode_a);
    end
  endtask

  task automatic test_kick_end();
    apply_reset();
    start_sweep();
    to_tick(58);
    flick_a = 1'b1;
    to_tick(59);
    flick_a = 1'b0;
    checks++;
    if (mode_a !== 3'd5 || busy_a !== 1'b1 || led_a !== 16'h0000) begin
      errors++; $display("FAIL kick_end_t59: mode=%0d busy=%b led=%h, want 5/1/0000", mode_a, busy_a, led_a);
    end
    to_tick(60);
    checks++;
    if (led_a !== 16'h0001 || mode_a !== 3'd5) begin
      errors++; $display("FAIL kick_end_t60: led=%h mode=%0d, want 0001/5", led_a, mode_a);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    start_sweep();
    to_tick(9);
    checks++;
    if (led_a !== 16'h00FF || mode_a !== 3'd1) begin
      errors++; $display("FAIL mid_pre: led=%h mode=%0d, want 00FF/1", led_a, mode_a);
    end
    rst_a = 1'b1; flick_a = 1'b1;
    @(negedge clk);
    checks++;
    if (led_a !== 16'h0000 || mode_a !== 3'd0 || busy_a !== 1'b0 || tick_a !== 1'b0) begin
      errors++; $display("FAIL mid_reset: led=%h mode=%0d busy=%b tick=%b, want 0000/0/0/0", led_a, mode_a, busy_a, tick_a);
    end
    rst_a = 1'b0; flick_a = 1'b0;
  endtask

  task automatic test_small_cfg();
    logic [3:0] tick_seen;
    rst_s = 1'b1; flick_s = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (led_s !== 8'h00 || mode_s !== 3'd0 || busy_s !== 1'b0 || tick_s !== 1'b0) begin
      errors++; $display("FAIL small_reset: led=%h mode=%0d busy=%b tick=%b, want 00/0/0/0", led_s, mode_s, busy_s, tick_s);
    end
    rst_s = 1'b0; flick_s = 1'b1;
    #1 tick_seen[0] = tick_s;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      tick_seen[i] = tick_s;
    end
    checks++;
    if (tick_seen !== 4'b1000) begin
      errors++; $display("FAIL small_tick_phase: got %b, want 1000", tick_seen);
    end
    @(negedge clk);
    flick_s = 1'b0;
    checks++;
    if (mode_s !== 3'd1 || tick_s !== 1'b0) begin
      errors++; $display("FAIL small_t1: mode=%0d tick=%b, want 1/0", mode_s, tick_s);
    end
    repeat (32) @(negedge clk);
    checks++;
    if (led_s !== 8'hFF || mode_s !== 3'd1) begin
      errors++; $display("FAIL small_t9: led=%h mode=%0d, want FF/1", led_s, mode_s);
    end
    repeat (28) @(negedge clk);
    checks++;
    if (led_s !== 8'h03 || mode_s !== 3'd2) begin
      errors++; $display("FAIL small_t16: led=%h mode=%0d, want 03/2", led_s, mode_s);
    end
    repeat (64) @(negedge clk);
    checks++;
    if (led_s !== 8'h00 || mode_s !== 3'd6 || busy_s !== 1'b1) begin
      errors++; $display("FAIL small_t32: led=%h mode=%0d busy=%b, want 00/6/1", led_s, mode_s, busy_s);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (mode_s !== 3'd6) begin
      errors++; $display("FAIL small_pre_t33: mode=%0d, want 6", mode_s);
    end
    @(negedge clk);
    checks++;
    if (mode_s !== 3'd0 || busy_s !== 1'b0 || led_s !== 8'h00) begin
      errors++; $display("FAIL small_t33: mode=%0d busy=%b led=%h, want 0/0/00", mode_s, busy_s, led_s);
    end
  endtask

  initial begin
    rst_a = 1'b1; flick_a = 1'b0;
    rst_s = 1'b1; flick_s = 1'b0;
    test_reset();
    test_idle_hold();
    test_full_sweep();
    test_kick_lo();
    test_kick_zero();
    test_kick_end();
    test_reset_mid();
    test_small_cfg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bound_flasher_gen.md
# bound_flasher_gen

Parametrised successor of the 16-lamp bound flasher: drives an N-lamp thermometer bar through a fixed up/down sweep sequence with two configurable bound points and flick-controlled kickback. Fully synchronous single-clock design: an internal prescaler generates a step tick, replacing the derived-clock divider. Sits between the board-level flick input and the LED pins.

## Interface
- N_LED, 16, number of lamps (≥4)
- B_LO, 5, lower bound point, lamps lit; 0 < B_LO < B_HI
- B_HI, 10, upper bound point, lamps lit; B_HI < N_LED
- TICK_DIV, 1, clk cycles per step tick (≥1)
- clk  in  1  system clock; one clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- flick  in  1  start/kickback request; sampled only on tick cycles
- led_out  out  N_LED  thermometer: bits [cnt-1:0] = 1, others 0
- mode  out  3  current state encoding (see package)
- busy  out  1  1 when state ≠ IDLE
- tick  out  1  single-cycle step strobe (debug/verification)

## Operation
- cnt: CW = $clog2(N_LED+1) bits, range 0..N_LED; led_out decoded combinationally from registered cnt.
- States and targets: IDLE (—), UP_FULL (→N_LED), DN_LO (→B_LO), UP_MID (→B_HI), DN_ZERO (→0), UP_LO (→B_LO), DN_END (→0).
- Each tick: if cnt ≠ phase target, cnt moves one step toward target (+1 in UP_*, −1 in DN_*); if cnt = target, state advances, cnt unchanged. No action on non-tick cycles.
- IDLE: tick with flick=1 → UP_FULL; otherwise stay, cnt=0.
- Advance order: UP_FULL→DN_LO→UP_MID→DN_ZERO→UP_LO→DN_END→IDLE.
- Kickback (evaluated only on the advance tick):
  - DN_LO at B_LO, flick=1 → UP_FULL (re-climb from B_LO).
  - DN_ZERO at 0, flick=1 → UP_MID.
  - DN_END at 0, flick=1 → UP_LO.
  - flick=0 → normal advance.
- flick outside tick cycles and outside advance ticks has no effect (except the IDLE start).
- Illegal state encoding → IDLE, cnt=0 on next clk.
- Parameter violations: elaboration-time $error.

## Timing
- Reset: cnt=0, led_out=0, mode=IDLE, busy=0, tick=0, prescaler=0. rst wins over all simultaneous events; reset mid-sweep clears immediately on next edge.
- Prescaler: tick asserted on the cycle prescaler = TICK_DIV−1, then wraps to 0; first tick TICK_DIV cycles after rst deassert. TICK_DIV=1 → tick every cycle. Runs continuously, including IDLE.
- State/cnt update on the rising edge ending the tick cycle; led_out, mode, busy valid the following cycle with no additional latency.
- Full normal sequence (defaults): 59 ticks from start tick to IDLE inclusive.

## Structure
- Package bound_flasher_pkg: state enum (IDLE=0, UP_FULL=1, DN_LO=2, UP_MID=3, DN_ZERO=4, UP_LO=5, DN_END=6), mode width constant, default parameter values.
- Sub-module flasher_tick_gen (param TICK_DIV; ports clk, rst, tick) for the prescaler; FSM, counter and thermometer decode in the top.

## Test plan
- Defaults, TICK_DIV=1: rst 3 cycles → led_out=0, mode=0, busy=0; hold flick=0 for 100 cycles → no change.
- flick=1 for one cycle in IDLE, then 0 → after tick 17 led_out=16'hFFFF; after tick 29 16'h001F; after tick 35 16'h03FF; after tick 46 0; after tick 52 16'h001F; after tick 59 mode=IDLE, busy=0.
- Kickback at B_LO: flick=1 on tick 30 (DN_LO, cnt=5) → mode=UP_FULL, led_out climbs 16'h003F at tick 31 up to 16'hFFFF.
- Kickbacks at 0: flick=1 on tick 47 → UP_MID; flick=1 on DN_END advance tick → UP_LO, led_out 16'h0001 next tick.
- rst asserted mid-UP_FULL (cnt=8) simultaneous with flick=1 → next cycle all outputs at reset values.
- N_LED=8, B_LO=2, B_HI=5, TICK_DIV=4: tick every 4th cycle; full sweep reaches 8'hFF, ends IDLE after 1+9+7+4+6+3+3=33 ticks (132 cycles).
